// File: rtl/jpeg_bitstream_fifo_reader.sv
// Read-side drain engine for the JPEG bitstream FIFO: pulls fixed-size bursts (or a
// short tail on flush) out of the FIFO read port and presents them as a framed
// valid/ready stream for the DDR write master. Single clock domain (rclk).
module jpeg_bitstream_fifo_reader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_DEPTH_WIDTH = 9,
  parameter int unsigned BURST_LEN      = 16
) (
  input  logic                      rclk,
  input  logic                      rrst_n,
  output logic                      fifo_r_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rdata,
  input  logic                      fifo_rempty,
  input  logic [RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      burst_start,
  output logic [RD_DEPTH_WIDTH:0]   burst_len,
  output logic                      m_valid,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [15:0]               burst_cnt
);

  localparam int unsigned LW = RD_DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] FullLen = LW'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StRead, StSettle} state_e;

  state_e                state_q, state_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  start_q, start_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         req_cnt_q, req_cnt_d;   // reads issued this burst
  logic [LW-1:0]         wr_cnt_q, wr_cnt_d;     // words pushed into the buffer this burst
  logic                  rvalid_q;               // read issued last cycle, data on fifo_rdata now
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  buf_rd_q, buf_wr_q;
  logic [1:0]            buf_cnt_q;
  logic [15:0]           burst_cnt_q;

  logic                  pop, push, push_last, last_hs, credit;
  logic                  level_zero, full_go, flush_go;
  logic [2:0]            occ;

  assign level_zero = (fifo_rd_water_level == '0);
  assign full_go    = (fifo_rd_water_level >= FullLen);
  assign flush_go   = flush_pend_q && !level_zero && (fifo_rd_water_level < FullLen);

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_data_q[buf_rd_q];
  assign m_last  = m_valid && buf_last_q[buf_rd_q];
  assign pop     = m_valid && m_ready;
  assign push    = rvalid_q;
  assign last_hs = pop && m_last;

  assign push_last = ((wr_cnt_q + LW'(1)) == len_q);

  // Space check: what the buffer will hold next cycle, counting the word in flight.
  assign occ    = {1'b0, buf_cnt_q} + {2'b00, rvalid_q} - {2'b00, pop};
  assign credit = (occ < 3'd2);

  // The first READ cycle only announces the burst; reads start one cycle later.
  assign fifo_r_en = (state_q == StRead) && !start_q && (req_cnt_q < len_q) &&
                     !fifo_rempty && credit;

  assign burst_start = start_q;
  assign burst_len   = len_q;
  assign busy        = (state_q != StIdle);
  assign burst_cnt   = burst_cnt_q;

  // Next-state logic: burst selection in IDLE, flush bookkeeping, counters.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    len_d        = len_q;
    req_cnt_d    = req_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    flush_done   = 1'b0;
    flush_pend_d = flush_pend_q | flush_req;
    if (fifo_r_en) req_cnt_d = req_cnt_q + LW'(1);
    if (push)      wr_cnt_d  = wr_cnt_q + LW'(1);
    unique case (state_q)
      StIdle: begin
        if (full_go) begin
          state_d   = StRead;
          start_d   = 1'b1;
          len_d     = FullLen;
          req_cnt_d = '0;
          wr_cnt_d  = '0;
        end else if (flush_go) begin
          state_d   = StRead;
          start_d   = 1'b1;
          len_d     = fifo_rd_water_level;
          req_cnt_d = '0;
          wr_cnt_d  = '0;
        end else if (flush_pend_q && level_zero) begin
          flush_done   = 1'b1;
          flush_pend_d = flush_req;
        end
      end
      StRead: begin
        if (last_hs) state_d = StSettle;
      end
      // One idle cycle so the registered level catches up with the final reads.
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      start_q      <= 1'b0;
      len_q        <= '0;
      req_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rvalid_q     <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      start_q      <= start_d;
      len_q        <= len_d;
      req_cnt_q    <= req_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rvalid_q     <= fifo_r_en;
      if (last_hs) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  // Two-entry output buffer; returning data always has room thanks to the credit check.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      buf_rd_q      <= 1'b0;
      buf_wr_q      <= 1'b0;
      buf_cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[buf_wr_q] <= fifo_rdata;
        buf_last_q[buf_wr_q] <= push_last;
        buf_wr_q             <= ~buf_wr_q;
      end
      if (pop) buf_rd_q <= ~buf_rd_q;
      case ({push, pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_fifo_reader.sv
// Bench for jpeg_bitstream_fifo_reader: a behavioural FIFO supplies sequentially
// numbered words; a scenario table plus hand-written reset/flush sequences check framing,
// ordering, flow control and timing.
module tb_jpeg_bitstream_fifo_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned BL = 16;
  localparam logic [31:0] DBASE = 32'hC0DE_0000;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rempty;
  logic [AW:0]   lvl = '0;
  logic          flush_req;
  logic          flush_done;
  logic          burst_start;
  logic [AW:0]   burst_len;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic [15:0]   burst_cnt;

  logic          fill_en = 1'b0;
  logic [AW:0]   fill_n = '0;
  logic          force_empty = 1'b0;
  logic [31:0]   rd_seq = '0;

  always #5 rclk = ~rclk;

  jpeg_bitstream_fifo_reader #(
    .DATA_WIDTH    (DW),
    .RD_DEPTH_WIDTH(AW),
    .BURST_LEN     (BL)
  ) dut (
    .rclk               (rclk),
    .rrst_n             (rrst_n),
    .fifo_r_en          (fifo_r_en),
    .fifo_rdata         (fifo_rdata),
    .fifo_rempty        (fifo_rempty),
    .fifo_rd_water_level(lvl),
    .flush_req          (flush_req),
    .flush_done         (flush_done),
    .burst_start        (burst_start),
    .burst_len          (burst_len),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .busy               (busy),
    .burst_cnt          (burst_cnt)
  );

  // Behavioural FIFO: registered level, data one cycle after the read enable.
  assign fifo_rempty = (lvl == '0) || force_empty;
  always @(posedge rclk) begin
    if (fill_en) lvl <= fill_n;
    else if (fifo_r_en && lvl != '0) lvl <= lvl - 1'b1;
    if (fifo_r_en) begin
      fifo_rdata <= DBASE + rd_seq;
      rd_seq     <= rd_seq + 32'd1;
    end
  end

  typedef struct {
    int fill;
    int flush_at;
    int rdy_mode;    // 0: always ready, 1: ready pattern 1,0,0,1
    bit stall;       // glitch fifo_rempty high every 5th cycle
    int cycles;
    int exp_bursts;
    int exp_len0;
    int exp_len1;
    int exp_words;
    int exp_done;
    int exp_lvl;
    bit chk_timing;
    int exp_span;    // last handshake minus first m_valid of burst 0, -1 to skip
  } vec_t;

  vec_t vecs[5];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_pop = 0;
  int exp_seq = 0;
  int exp_bc = 0;
  int sc_bursts, sc_words, sc_rd, sc_done, sc_bs0, sc_first_rd, sc_first_v, sc_hs0, sc_gap;
  int sc_len[2];
  int max_out, data_err, last_err, hold_err;
  int widx = 0;
  int cur_len = 0;
  int last_hs_cyc = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;
  bit found;
  bit rdy;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sc_clear();
    sc_bursts = 0; sc_words = 0; sc_rd = 0; sc_done = 0;
    sc_bs0 = -1; sc_first_rd = -1; sc_first_v = -1; sc_hs0 = -1; sc_gap = -1;
    sc_len[0] = 0; sc_len[1] = 0;
    max_out = 0; data_err = 0; last_err = 0; hold_err = 0;
  endtask

  // Mid-cycle observation of every DUT output.
  task automatic observe();
    cyc++;
    if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last)) hold_err++;
    if (fifo_r_en) begin
      if (sc_first_rd < 0) sc_first_rd = cyc;
      n_rd++;
      sc_rd++;
    end
    if (burst_start) begin
      if (sc_bursts < 2) sc_len[sc_bursts] = int'(burst_len);
      if (sc_bursts == 0) sc_bs0 = cyc;
      if (sc_bursts == 1) sc_gap = cyc - last_hs_cyc;
      sc_bursts++;
      cur_len = int'(burst_len);
      widx = 0;
    end
    if (m_valid && sc_first_v < 0) sc_first_v = cyc;
    if (m_valid && m_ready) begin
      if (m_data != DBASE + 32'(exp_seq)) data_err++;
      exp_seq++;
      n_pop++;
      sc_words++;
      widx++;
      if (m_last != (widx == cur_len)) last_err++;
      if (m_last) begin
        last_hs_cyc = cyc;
        if (sc_hs0 < 0) sc_hs0 = cyc;
      end
    end
    if (flush_done) sc_done++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  // Drive one cycle's inputs just after the edge, then observe at the falling edge.
  task automatic tick(input bit rst_n, input bit ready, input bit flush, input bit stall,
                      input bit fill, input int fill_words);
    @(posedge rclk);
    #1;
    rrst_n      = rst_n;
    m_ready     = ready;
    flush_req   = flush;
    force_empty = stall;
    fill_en     = fill;
    fill_n      = (AW+1)'(fill_words);
    @(negedge rclk);
    observe();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_r_en"}, fifo_r_en, 0);
    check({tag, "_flush_done"}, flush_done, 0);
    check({tag, "_burst_start"}, burst_start, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_burst_len"}, burst_len, 0);
    check({tag, "_burst_cnt"}, burst_cnt, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst_n = 1'b0; m_ready = 1'b0; flush_req = 1'b0;

    //          fill flush mode stall cyc bursts len0 len1 words done lvl timing span
    vecs[0] = '{40,  -1,   0,   1'b0, 90, 2,     16,  16,  32,   0,   8,  1'b1,  15};
    vecs[1] = '{5,    3,   0,   1'b0, 60, 1,     5,   0,   5,    1,   0,  1'b1,  4};
    vecs[2] = '{16,  -1,   1,   1'b0, 80, 1,     16,  0,   16,   0,   0,  1'b1,  -1};
    vecs[3] = '{19,   5,   0,   1'b0, 80, 2,     16,  3,   19,   1,   0,  1'b1,  15};
    vecs[4] = '{16,  -1,   0,   1'b1, 80, 1,     16,  0,   16,   0,   0,  1'b0,  -1};

    sc_clear();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_reset_outputs("rst0");

    for (int v = 0; v < 5; v++) begin
      sc_clear();
      for (int c = 0; c < vecs[v].cycles; c++) begin
        rdy = (vecs[v].rdy_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
        tick(1'b1, rdy, (c == vecs[v].flush_at), vecs[v].stall && (c % 5 == 2),
             (c == 0), vecs[v].fill);
      end
      exp_bc += vecs[v].exp_bursts;
      check($sformatf("v%0d_bursts", v), sc_bursts, vecs[v].exp_bursts);
      check($sformatf("v%0d_len0", v), sc_len[0], vecs[v].exp_len0);
      if (vecs[v].exp_bursts > 1) begin
        check($sformatf("v%0d_len1", v), sc_len[1], vecs[v].exp_len1);
        check($sformatf("v%0d_gap", v), sc_gap, 3);
      end
      check($sformatf("v%0d_words", v), sc_words, vecs[v].exp_words);
      check($sformatf("v%0d_reads", v), sc_rd, vecs[v].exp_words);
      check($sformatf("v%0d_flush_done", v), sc_done, vecs[v].exp_done);
      check($sformatf("v%0d_level_end", v), lvl, vecs[v].exp_lvl);
      check($sformatf("v%0d_burst_cnt", v), burst_cnt, exp_bc % 65536);
      check($sformatf("v%0d_data_order", v), data_err, 0);
      check($sformatf("v%0d_last_pos", v), last_err, 0);
      check($sformatf("v%0d_hold", v), hold_err, 0);
      check($sformatf("v%0d_max_outstanding", v), max_out, 2);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      if (vecs[v].chk_timing) begin
        check($sformatf("v%0d_first_read_lat", v), sc_first_rd - sc_bs0, 1);
        check($sformatf("v%0d_first_valid_lat", v), sc_first_v - sc_bs0, 3);
      end
      if (vecs[v].exp_span >= 0)
        check($sformatf("v%0d_span", v), sc_hs0 - sc_first_v, vecs[v].exp_span);
    end

    // Flush request in IDLE with an empty FIFO: done one cycle later, no burst.
    sc_clear();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("flush_empty_t0", flush_done, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("flush_empty_t1", flush_done, 1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("flush_empty_t2", flush_done, 0);
    for (int c = 0; c < 5; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("flush_empty_no_burst", sc_bursts, 0);
    check("flush_empty_done_cnt", sc_done, 1);

    // Reset asserted at the 7th word of a burst.
    sc_clear();
    found = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32);
    for (int c = 0; c < 40 && !found; c++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      if (widx == 7 && sc_bursts == 1) found = 1'b1;
    end
    check("rst7_reached", found, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_reset_outputs("rst7");
    // Words already read are dropped by the DUT; realign the expected sequence.
    n_pop = n_rd;
    exp_seq = n_rd;
    exp_bc = 0;
    prev_stall = 1'b0;
    sc_clear();
    for (int c = 0; c < 20 && sc_bursts == 0; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("rst7_restart", sc_bursts, 1);
    check("rst7_restart_len", sc_len[0], 16);
    for (int c = 0; c < 40; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("rst7_words", sc_words, 16);
    check("rst7_data_order", data_err, 0);
    check("rst7_last_pos", last_err, 0);
    check("rst7_burst_cnt", burst_cnt, 1);
    check("rst7_first_read_lat", sc_first_rd - sc_bs0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
